dsp48a1_slice: RTL and testbench

// Spartan-6 style DSP slice: 18-bit pre-adder/subtracter, 18x18 unsigned multiplier, 48-bit post-adder/subtracter/accumulator.

---
 rtl/dsp48a1_slice.sv | 158 +++++++++++++++
 tb/tb_dsp48a1_slice.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48a1_slice.sv
// Spartan-6 style DSP slice: 18-bit pre-adder, 18x18 unsigned multiplier and 48-bit post-adder/accumulator.
// Each pipeline stage can be registered or bypassed by parameter; BCOUT/PCOUT chain into the next slice.

module dsp48a1_stage #(
  parameter int WIDTH = 18,
  parameter int REG   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // The flop is always described; when the stage is bypassed its output is unused and gets trimmed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (ce) begin
      q_r <= d;
    end
  end

  assign q = (REG != 0) ? q_r : d;

endmodule

module dsp48a1_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        clk,
  input  logic        rsta,
  input  logic        rstb,
  input  logic        rstc,
  input  logic        rstcarryin,
  input  logic        rstd,
  input  logic        rstm,
  input  logic        rstopmode,
  input  logic        rstp,
  input  logic        cea,
  input  logic        ceb,
  input  logic        cec,
  input  logic        cecarryin,
  input  logic        ced,
  input  logic        cem,
  input  logic        ceopmode,
  input  logic        cep,
  input  logic [17:0] a,
  input  logic [17:0] b,
  input  logic [17:0] d,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [7:0]  opmode,
  input  logic [17:0] bcin,
  input  logic [47:0] pcin,
  output logic [35:0] m,
  output logic [47:0] p,
  output logic        carryout,
  output logic        carryoutf,
  output logic [17:0] bcout,
  output logic [47:0] pcout
);

  localparam bit B_DIRECT  = (B_INPUT == "DIRECT");
  localparam bit B_CASCADE = (B_INPUT == "CASCADE");
  localparam bit CIN_OP5   = (CARRYINSEL == "OPMODE5");
  localparam bit CIN_PORT  = (CARRYINSEL == "CARRYIN");

  logic [17:0] d_q, b0_src, b0_q, a0_q, b1_in, b1_q, a1_q;
  logic [47:0] c_q, x_mux, z_mux, p_q;
  logic [7:0]  op_q;
  logic [35:0] m_in, m_q;
  logic        cin_sel, cyi_q, co_q;
  logic [48:0] post_sum;

  assign b0_src = B_DIRECT ? b : (B_CASCADE ? bcin : 18'd0);

  dsp48a1_stage #(.WIDTH(18), .REG(DREG))      u_dreg  (.clk(clk), .rst_n(rstd),      .ce(ced),      .d(d),      .q(d_q));
  dsp48a1_stage #(.WIDTH(18), .REG(B0REG))     u_b0reg (.clk(clk), .rst_n(rstb),      .ce(ceb),      .d(b0_src), .q(b0_q));
  dsp48a1_stage #(.WIDTH(18), .REG(A0REG))     u_a0reg (.clk(clk), .rst_n(rsta),      .ce(cea),      .d(a),      .q(a0_q));
  dsp48a1_stage #(.WIDTH(48), .REG(CREG))      u_creg  (.clk(clk), .rst_n(rstc),      .ce(cec),      .d(c),      .q(c_q));
  dsp48a1_stage #(.WIDTH(8),  .REG(OPMODEREG)) u_opreg (.clk(clk), .rst_n(rstopmode), .ce(ceopmode), .d(opmode), .q(op_q));

  // Pre-adder works on the stage-1 D and B values and wraps within 18 bits.
  always_comb begin
    b1_in = b0_q;
    if (op_q[4]) begin
      b1_in = op_q[6] ? (d_q - b0_q) : (d_q + b0_q);
    end
  end

  dsp48a1_stage #(.WIDTH(18), .REG(B1REG)) u_b1reg (.clk(clk), .rst_n(rstb), .ce(ceb), .d(b1_in), .q(b1_q));
  dsp48a1_stage #(.WIDTH(18), .REG(A1REG)) u_a1reg (.clk(clk), .rst_n(rsta), .ce(cea), .d(a0_q),  .q(a1_q));

  assign m_in = {18'd0, a1_q} * {18'd0, b1_q};

  dsp48a1_stage #(.WIDTH(36), .REG(MREG)) u_mreg (.clk(clk), .rst_n(rstm), .ce(cem), .d(m_in), .q(m_q));

  assign cin_sel = CIN_OP5 ? op_q[5] : (CIN_PORT ? carryin : 1'b0);

  dsp48a1_stage #(.WIDTH(1), .REG(CARRYINREG)) u_cyireg (.clk(clk), .rst_n(rstcarryin), .ce(cecarryin), .d(cin_sel), .q(cyi_q));

  // X and Z operand selection; the P path feeds back the current result for accumulation.
  always_comb begin
    x_mux = 48'd0;
    case (op_q[1:0])
      2'b00: x_mux = 48'd0;
      2'b01: x_mux = {12'd0, m_q};
      2'b10: x_mux = p_q;
      2'b11: x_mux = {d_q[11:0], a1_q, b1_q};
      default: x_mux = 48'd0;
    endcase
  end

  always_comb begin
    z_mux = 48'd0;
    case (op_q[3:2])
      2'b00: z_mux = 48'd0;
      2'b01: z_mux = pcin;
      2'b10: z_mux = p_q;
      2'b11: z_mux = c_q;
      default: z_mux = 48'd0;
    endcase
  end

  // Bit 48 carries the add carry or the subtract borrow.
  always_comb begin
    post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cyi_q};
    if (op_q[7]) begin
      post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cyi_q});
    end
  end

  dsp48a1_stage #(.WIDTH(48), .REG(PREG))        u_preg  (.clk(clk), .rst_n(rstp),       .ce(cep), .d(post_sum[47:0]), .q(p_q));
  dsp48a1_stage #(.WIDTH(1),  .REG(CARRYOUTREG)) u_coreg (.clk(clk), .rst_n(rstcarryin), .ce(cep), .d(post_sum[48]),   .q(co_q));

  assign m         = m_q;
  assign p         = p_q;
  assign pcout     = p_q;
  assign bcout     = b1_q;
  assign carryout  = co_q;
  assign carryoutf = co_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice (default parameters): a reference model pushes expected outputs each
// cycle, a monitor pops and compares them, and a few hand-computed results are checked as constants.

module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        rsta, rstb, rstc, rstcarryin, rstd, rstm, rstopmode, rstp;
  logic        cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep;
  logic [17:0] a, b, d, bcin;
  logic [47:0] c, pcin;
  logic        carryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] p, pcout;
  logic        carryout, carryoutf;
  logic [17:0] bcout;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [47:0] p;
    logic [35:0] m;
    logic [17:0] bcout;
    logic        co;
  } exp_t;

  exp_t expq[$];

  // Reference model state: the registered copies of D, C, OPMODE, B1, A1, M, carry-in, P and carry-out.
  logic [17:0] md, mb1, ma1;
  logic [47:0] mc, mp;
  logic [7:0]  mop;
  logic [35:0] mm;
  logic        mcyi, mco;

  dsp48a1_slice dut (
    .clk(clk), .rsta(rsta), .rstb(rstb), .rstc(rstc), .rstcarryin(rstcarryin), .rstd(rstd),
    .rstm(rstm), .rstopmode(rstopmode), .rstp(rstp),
    .cea(cea), .ceb(ceb), .cec(cec), .cecarryin(cecarryin), .ced(ced), .cem(cem),
    .ceopmode(ceopmode), .cep(cep),
    .a(a), .b(b), .d(d), .c(c), .carryin(carryin), .opmode(opmode), .bcin(bcin), .pcin(pcin),
    .m(m), .p(p), .carryout(carryout), .carryoutf(carryoutf), .bcout(bcout), .pcout(pcout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setResets(input logic v);
    rsta = v; rstb = v; rstc = v; rstcarryin = v; rstd = v; rstm = v; rstopmode = v; rstp = v;
  endtask

  task automatic setEnables(input logic v);
    cea = v; ceb = v; cec = v; cecarryin = v; ced = v; cem = v; ceopmode = v; cep = v;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [17:0] av, input logic [17:0] bv,
                               input logic [17:0] dv, input logic [47:0] cv, input logic [47:0] pv);
    opmode = op; a = av; b = bv; d = dv; c = cv; pcin = pv;
  endtask

  // Model: sample the inputs seen at the edge, advance every stage with plain arithmetic, then apply
  // whatever asynchronous clears the driver has asserted for the coming cycle.
  initial begin
    logic [17:0] s_a, s_b, s_d, pre;
    logic [47:0] s_c, s_pcin, xv, zv;
    logic [7:0]  s_op;
    logic [48:0] sum;
    logic [7:0]  s_rst, s_ce;
    md = '0; mb1 = '0; ma1 = '0; mc = '0; mp = '0; mop = '0; mm = '0; mcyi = 1'b0; mco = 1'b0;
    forever begin
      @(posedge clk);
      s_a = a; s_b = b; s_d = d; s_c = c; s_pcin = pcin; s_op = opmode;
      s_rst = {rsta, rstb, rstc, rstcarryin, rstd, rstm, rstopmode, rstp};
      s_ce  = {cea, ceb, cec, cecarryin, ced, cem, ceopmode, cep};
      #2;
      pre = mop[4] ? (mop[6] ? md - s_b : md + s_b) : s_b;
      case (mop[1:0])
        2'd0: xv = 48'd0;
        2'd1: xv = {12'd0, mm};
        2'd2: xv = mp;
        default: xv = {md[11:0], ma1, mb1};
      endcase
      case (mop[3:2])
        2'd0: zv = 48'd0;
        2'd1: zv = s_pcin;
        2'd2: zv = mp;
        default: zv = mc;
      endcase
      if (mop[7]) sum = {1'b0, zv} - {1'b0, xv} - {48'd0, mcyi};
      else        sum = {1'b0, zv} + {1'b0, xv} + {48'd0, mcyi};
      // Bit order of s_rst/s_ce: a, b, c, carryin, d, m, opmode, p.
      if (!s_rst[0]) begin mp = '0; end else if (s_ce[0]) begin mp = sum[47:0]; end
      if (!s_rst[4]) begin mco = 1'b0; end else if (s_ce[0]) begin mco = sum[48]; end
      if (!s_rst[4]) begin mcyi = 1'b0; end else if (s_ce[4]) begin mcyi = mop[5]; end
      if (!s_rst[2]) begin mm = '0; end else if (s_ce[2]) begin mm = ma1 * mb1; end
      if (!s_rst[6]) begin mb1 = '0; end else if (s_ce[6]) begin mb1 = pre; end
      if (!s_rst[7]) begin ma1 = '0; end else if (s_ce[7]) begin ma1 = s_a; end
      if (!s_rst[3]) begin md = '0; end else if (s_ce[3]) begin md = s_d; end
      if (!s_rst[5]) begin mc = '0; end else if (s_ce[5]) begin mc = s_c; end
      if (!s_rst[1]) begin mop = '0; end else if (s_ce[1]) begin mop = s_op; end
      if (!rstp)       mp = '0;
      if (!rstcarryin) begin mco = 1'b0; mcyi = 1'b0; end
      if (!rstm)       mm = '0;
      if (!rstb)       mb1 = '0;
      if (!rsta)       ma1 = '0;
      if (!rstd)       md = '0;
      if (!rstc)       mc = '0;
      if (!rstopmode)  mop = '0;
      expq.push_back('{p: mp, m: mm, bcout: mb1, co: mco});
    end
  end

  // Monitor: every cycle the DUT presents a fresh result, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("sb_p",         p,                   e.p);
        checkOutput("sb_pcout",     pcout,               e.p);
        checkOutput("sb_m",         {12'd0, m},          {12'd0, e.m});
        checkOutput("sb_bcout",     {30'd0, bcout},      {30'd0, e.bcout});
        checkOutput("sb_carryout",  {47'd0, carryout},   {47'd0, e.co});
        checkOutput("sb_carryoutf", {47'd0, carryoutf},  {47'd0, e.co});
      end
    end
  end

  initial begin
    setResets(1'b1);
    setEnables(1'b1);
    carryin = 1'b1; bcin = 18'h155;
    applyStimulus(8'hFF, 18'd123, 18'd77, 18'd99, 48'd4242, 48'd17);
    #1;
    setResets(1'b0);
    stepCycles(2);
    @(negedge clk);
    checkOutput("rst_p",         p,                  48'd0);
    checkOutput("rst_m",         {12'd0, m},         48'd0);
    checkOutput("rst_bcout",     {30'd0, bcout},     48'd0);
    checkOutput("rst_carryout",  {47'd0, carryout},  48'd0);
    checkOutput("rst_carryoutf", {47'd0, carryoutf}, 48'd0);
    checkOutput("rst_pcout",     pcout,              48'd0);
    stepCycles(1);
    setResets(1'b1);

    applyStimulus(8'h10, 18'd3, 18'd5, 18'd100, 48'd0, 48'd0);
    stepCycles(4);
    @(negedge clk);
    checkOutput("preadd_bcout", {30'd0, bcout}, 48'd105);
    checkOutput("preadd_m",     {12'd0, m},     48'd315);
    stepCycles(1);
    opmode = 8'h50;
    stepCycles(4);
    @(negedge clk);
    checkOutput("presub_bcout", {30'd0, bcout}, 48'd95);
    checkOutput("presub_m",     {12'd0, m},     48'd285);

    stepCycles(1);
    applyStimulus(8'h01, 18'd7, 18'd6, 18'd0, 48'd0, 48'd0);
    stepCycles(5);
    @(negedge clk);
    checkOutput("mul_m", {12'd0, m}, 48'd42);
    checkOutput("mul_p", p,          48'd42);

    stepCycles(1);
    applyStimulus(8'h8D, 18'd2, 18'd3, 18'd0, 48'd1000, 48'd0);
    stepCycles(5);
    @(negedge clk);
    checkOutput("postsub_p",  p,                 48'd994);
    checkOutput("postsub_co", {47'd0, carryout}, 48'd0);
    stepCycles(1);
    applyStimulus(8'h8D, 18'd1, 18'd2, 18'd0, 48'd1, 48'd0);
    stepCycles(5);
    @(negedge clk);
    checkOutput("borrow_p",   p,                 48'hFFFF_FFFF_FFFF);
    checkOutput("borrow_co",  {47'd0, carryout}, 48'd1);

    stepCycles(1);
    applyStimulus(8'h0E, 18'd0, 18'd0, 18'd0, 48'd5, 48'd0);
    stepCycles(3);
    rstp = 1'b0;
    stepCycles(1);
    rstp = 1'b1;
    @(negedge clk);
    checkOutput("acc_0", p, 48'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput("acc_step", p, 48'(5 * i));
    end
    stepCycles(1);
    cep = 1'b0;
    stepCycles(3);
    @(negedge clk);
    checkOutput("cep_hold", p, 48'd20);
    stepCycles(1);
    cep = 1'b1;

    applyStimulus(8'h06, 18'd0, 18'd0, 18'd0, 48'd0, 48'd3);
    stepCycles(3);
    rstp = 1'b0;
    stepCycles(1);
    rstp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pcin_acc1", p, 48'd3);
    @(negedge clk);
    checkOutput("pcin_acc2", p, 48'd6);

    stepCycles(1);
    applyStimulus(8'h2C, 18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0);
    stepCycles(5);
    @(negedge clk);
    checkOutput("carry_p",   p,                  48'd0);
    checkOutput("carry_co",  {47'd0, carryout},  48'd1);
    checkOutput("carry_cof", {47'd0, carryoutf}, 48'd1);

    // Random operands, opmodes, enables and occasional per-stage resets, all checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      stepCycles(1);
      applyStimulus(8'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
                    {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)});
      carryin = 1'($urandom);
      bcin = 18'($urandom);
      cea = ($urandom_range(0, 7) != 0); ceb = ($urandom_range(0, 7) != 0);
      cec = ($urandom_range(0, 7) != 0); cecarryin = ($urandom_range(0, 7) != 0);
      ced = ($urandom_range(0, 7) != 0); cem = ($urandom_range(0, 7) != 0);
      ceopmode = ($urandom_range(0, 7) != 0); cep = ($urandom_range(0, 7) != 0);
      rsta = ($urandom_range(0, 19) != 0); rstb = ($urandom_range(0, 19) != 0);
      rstc = ($urandom_range(0, 19) != 0); rstcarryin = ($urandom_range(0, 19) != 0);
      rstd = ($urandom_range(0, 19) != 0); rstm = ($urandom_range(0, 19) != 0);
      rstopmode = ($urandom_range(0, 19) != 0); rstp = ($urandom_range(0, 19) != 0);
    end

    stepCycles(1);
    setResets(1'b1);
    setEnables(1'b1);
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
